uart_rx_deframer: RTL and testbench

UART_RX_DEFRAMER -- requirements
Module: uart_rx_deframer

---
 rtl/uart_rx_deframer.sv | 143 ++++++++++++++
 tb/tb_uart_rx_deframer.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_deframer.sv
// 8N1 UART receiver: synchronizes rx, deframes bytes with mid-bit sampling and
// presents them through a one-deep valid/ready holding register.
module uart_rx_deframer #(
   parameter int CLK_DIV = 16
) (
   input  logic       clk_sis,
   input  logic       rst,
   input  logic       rx,
   output logic [7:0] data_out,
   output logic       data_valid,
   input  logic       data_ready,
   output logic       frame_err,
   output logic       overrun,
   output logic       busy
);

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      STOP,
      WAIT_HIGH
   } state_t;

   localparam logic [11:0] HALF_LAST = 12'(CLK_DIV / 2 - 1);
   localparam logic [11:0] BIT_LAST  = 12'(CLK_DIV - 1);

   state_t      state, state_next;
   logic [11:0] cnt, cnt_next;
   logic [2:0]  idx, idx_next;
   logic [7:0]  shift, shift_next;
   logic        rx_meta, rx_s;
   logic        settle, armed;
   logic        good, bad;

   always_ff @(posedge clk_sis or posedge rst) begin
      if (rst) begin
         rx_meta <= 1'b1;
         rx_s    <= 1'b1;
      end else begin
         rx_meta <= rx;
         rx_s    <= rx_meta;
      end
   end

   // The synchronizer resets high, so a line held low through reset would look
   // like a falling edge; require a genuinely observed high line before arming.
   always_ff @(posedge clk_sis or posedge rst) begin
      if (rst) begin
         settle <= 1'b0;
         armed  <= 1'b0;
      end else begin
         settle <= 1'b1;
         if (settle && rx_meta && rx_s) armed <= 1'b1;
      end
   end

   always_ff @(posedge clk_sis or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         cnt   <= '0;
         idx   <= '0;
         shift <= '0;
      end else begin
         state <= state_next;
         cnt   <= cnt_next;
         idx   <= idx_next;
         shift <= shift_next;
      end
   end

   // NOTE: every signal gets a default before the case so no latch is inferred.
   always_comb begin
      state_next = state;
      cnt_next   = cnt + 12'd1;
      idx_next   = idx;
      shift_next = shift;
      good       = 1'b0;
      bad        = 1'b0;
      case (state)
         IDLE: begin
            cnt_next = '0;
            if (armed && !rx_s) state_next = START;
         end
         START: begin
            if (cnt == HALF_LAST) begin
               cnt_next = '0;
               idx_next = '0;
               state_next = rx_s ? IDLE : DATA;
            end
         end
         DATA: begin
            if (cnt == BIT_LAST) begin
               cnt_next        = '0;
               shift_next[idx] = rx_s;
               idx_next        = idx + 3'd1;
               if (idx == 3'd7) state_next = STOP;
            end
         end
         STOP: begin
            if (cnt == BIT_LAST) begin
               cnt_next = '0;
               if (rx_s) begin
                  good       = 1'b1;
                  state_next = IDLE;
               end else begin
                  bad        = 1'b1;
                  state_next = WAIT_HIGH;
               end
            end
         end
         WAIT_HIGH: begin
            cnt_next = '0;
            if (rx_s) state_next = IDLE;
         end
         default: begin
            cnt_next   = '0;
            state_next = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk_sis or posedge rst) begin
      if (rst) begin
         data_out   <= 8'h00;
         data_valid <= 1'b0;
         frame_err  <= 1'b0;
         overrun    <= 1'b0;
      end else begin
         frame_err <= bad;
         overrun   <= good && data_valid && !data_ready;
         if (good && (!data_valid || data_ready)) begin
            data_out   <= shift;
            data_valid <= 1'b1;
         end else if (data_valid && data_ready) begin
            data_valid <= 1'b0;
         end
      end
   end

   assign busy = (state != IDLE);

endmodule

// File: tb/tb_uart_rx_deframer.sv
// Directed bench for uart_rx_deframer at CLK_DIV=16: a frame table plus
// hand-written latency, back-to-back, overrun, break, glitch and reset cases.
module tb_uart_rx_deframer;

   localparam int D = 16;

   logic       clk_sis = 1'b0;
   logic       rst;
   logic       rx;
   logic [7:0] data_out;
   logic       data_valid;
   logic       data_ready;
   logic       frame_err;
   logic       overrun;
   logic       busy;

   int errors = 0;
   int checks = 0;
   int n_ferr = 0;
   int n_ovr  = 0;
   logic [7:0] got[$];

   typedef struct {
      logic [7:0] byte_in;
      logic       stop_bit;
      logic       exp_valid;
      logic [7:0] exp_data;
      int         exp_ferr;
   } vec_t;

   vec_t vecs[5];

   uart_rx_deframer #(.CLK_DIV(D)) dut (
      .clk_sis    (clk_sis),
      .rst        (rst),
      .rx         (rx),
      .data_out   (data_out),
      .data_valid (data_valid),
      .data_ready (data_ready),
      .frame_err  (frame_err),
      .overrun    (overrun),
      .busy       (busy)
   );

   always #5 clk_sis = ~clk_sis;

   always @(negedge clk_sis) begin
      if (!rst) begin
         if (frame_err) n_ferr++;
         if (overrun) n_ovr++;
         if (data_valid && data_ready) got.push_back(data_out);
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // Called at a negedge; drives start, 8 data bits LSB first, stop bit.
   task automatic send_frame(input logic [7:0] b, input logic stop_bit, input logic idle_after);
      rx = 1'b0;
      repeat (D) @(negedge clk_sis);
      for (int i = 0; i < 8; i++) begin
         rx = b[i];
         repeat (D) @(negedge clk_sis);
      end
      rx = stop_bit;
      repeat (D) @(negedge clk_sis);
      rx = idle_after;
   endtask

   task automatic drain();
      @(posedge clk_sis);
      #2 data_ready = 1'b1;
      @(posedge clk_sis);
      #2 data_ready = 1'b0;
      @(negedge clk_sis);
   endtask

   initial begin
      int f0, o0;
      vecs[0] = '{8'hA5, 1'b1, 1'b1, 8'hA5, 0};
      vecs[1] = '{8'h00, 1'b1, 1'b1, 8'h00, 0};
      vecs[2] = '{8'hFF, 1'b1, 1'b1, 8'hFF, 0};
      vecs[3] = '{8'h12, 1'b0, 1'b0, 8'hFF, 1};
      vecs[4] = '{8'h5A, 1'b1, 1'b1, 8'h5A, 0};

      rst = 1'b1;
      rx = 1'b1;
      data_ready = 1'b0;
      repeat (3) @(posedge clk_sis);
      #1;
      check("reset data_out", 32'(data_out), 32'h00);
      check("reset data_valid", 32'(data_valid), 32'h0);
      check("reset busy", 32'(busy), 32'h0);
      check("reset frame_err", 32'(frame_err), 32'h0);
      check("reset overrun", 32'(overrun), 32'h0);
      @(negedge clk_sis);
      rst = 1'b0;
      repeat (5) @(negedge clk_sis);

      // Latency: valid low one cycle before, high exactly 154 edges after E0.
      fork
         send_frame(8'hA5, 1'b1, 1'b1);
         begin
            repeat (154) @(posedge clk_sis);
            #1 check("latency valid before 154", 32'(data_valid), 32'h0);
            @(posedge clk_sis);
            #1 check("latency valid at 154", 32'(data_valid), 32'h1);
            check("latency data", 32'(data_out), 32'hA5);
         end
      join
      repeat (50) @(negedge clk_sis);
      check("hold valid", 32'(data_valid), 32'h1);
      check("hold data", 32'(data_out), 32'hA5);
      @(posedge clk_sis);
      #2 data_ready = 1'b1;
      @(posedge clk_sis);
      #1 check("valid cleared by ready", 32'(data_valid), 32'h0);
      data_ready = 1'b0;
      @(negedge clk_sis);

      // Table of single frames, consumer idle.
      for (int i = 0; i < 5; i++) begin
         drain();
         f0 = n_ferr;
         send_frame(vecs[i].byte_in, vecs[i].stop_bit, 1'b1);
         repeat (20) @(negedge clk_sis);
         check($sformatf("vec%0d valid", i), 32'(data_valid), 32'(vecs[i].exp_valid));
         if (vecs[i].exp_valid)
            check($sformatf("vec%0d data", i), 32'(data_out), 32'(vecs[i].exp_data));
         check($sformatf("vec%0d frame_err count", i), 32'(n_ferr - f0), 32'(vecs[i].exp_ferr));
         check($sformatf("vec%0d busy", i), 32'(busy), 32'h0);
      end

      // Back-to-back frames with the consumer always ready.
      drain();
      got.delete();
      o0 = n_ovr;
      @(posedge clk_sis);
      #2 data_ready = 1'b1;
      @(negedge clk_sis);
      send_frame(8'h3C, 1'b1, 1'b1);
      send_frame(8'h81, 1'b1, 1'b1);
      repeat (20) @(negedge clk_sis);
      check("b2b count", 32'(got.size()), 32'd2);
      if (got.size() == 2) begin
         check("b2b byte0", 32'(got[0]), 32'h3C);
         check("b2b byte1", 32'(got[1]), 32'h81);
      end
      check("b2b overrun", 32'(n_ovr - o0), 32'd0);
      @(posedge clk_sis);
      #2 data_ready = 1'b0;
      @(negedge clk_sis);

      // Overrun: second byte arrives while first is unconsumed.
      drain();
      o0 = n_ovr;
      send_frame(8'h55, 1'b1, 1'b1);
      send_frame(8'hFF, 1'b1, 1'b1);
      repeat (10) @(negedge clk_sis);
      check("overrun count", 32'(n_ovr - o0), 32'd1);
      check("overrun data kept", 32'(data_out), 32'h55);
      check("overrun valid", 32'(data_valid), 32'h1);

      // Bad stop bit followed by a 40-bit break.
      drain();
      f0 = n_ferr;
      send_frame(8'h12, 1'b0, 1'b0);
      repeat (40 * D) @(negedge clk_sis);
      check("break frame_err count", 32'(n_ferr - f0), 32'd1);
      check("break valid", 32'(data_valid), 32'h0);
      check("break busy", 32'(busy), 32'h1);
      rx = 1'b1;
      repeat (5) @(negedge clk_sis);
      check("break recovered busy", 32'(busy), 32'h0);

      // Four-cycle low glitch.
      f0 = n_ferr;
      o0 = n_ovr;
      rx = 1'b0;
      repeat (4) @(negedge clk_sis);
      rx = 1'b1;
      repeat (2) @(negedge clk_sis);
      check("glitch busy in start", 32'(busy), 32'h1);
      repeat (30) @(negedge clk_sis);
      check("glitch back to idle", 32'(busy), 32'h0);
      check("glitch valid", 32'(data_valid), 32'h0);
      check("glitch pulses", 32'((n_ferr - f0) + (n_ovr - o0)), 32'd0);

      // Reset during bit 4 of 0xC3 (line low at release), then a clean 0x7E.
      got.delete();
      fork
         send_frame(8'hC3, 1'b1, 1'b1);
         begin
            repeat (5 * D + 8) @(negedge clk_sis);
            rst = 1'b1;
            repeat (3) @(negedge clk_sis);
            check("midreset busy", 32'(busy), 32'h0);
            check("midreset data_out", 32'(data_out), 32'h00);
            rst = 1'b0;
         end
      join
      repeat (20) @(negedge clk_sis);
      check("after reset no valid", 32'(data_valid), 32'h0);
      send_frame(8'h7E, 1'b1, 1'b1);
      repeat (10) @(negedge clk_sis);
      check("after reset valid", 32'(data_valid), 32'h1);
      check("after reset data", 32'(data_out), 32'h7E);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
